// File: rtl/izh_pkg.sv
// Shared types, Q12.9 constants and the saturation helper for the Izhikevich core.
package izh_pkg;

    localparam int W        = 21;  // data word width
    localparam int FRAC     = 9;   // fractional bits, 1.0 = 512
    localparam int DT_SHIFT = 4;   // Euler step dt = 1/16 ms
    localparam int WI       = 48;  // width of intermediate sums, ample headroom for sq at |v| = 2^20

    localparam logic signed [W-1:0] K_SQ    = 21'sd20;     // 0.04 (0.0390625)
    localparam logic signed [W-1:0] K_LIN   = 21'sd2560;   // 5.0
    localparam logic signed [W-1:0] K_CONST = 21'sd71680;  // 140.0
    localparam logic signed [W-1:0] A_COEF  = 21'sd10;     // a = 0.02
    localparam logic signed [W-1:0] B_COEF  = 21'sd102;    // b = 0.2
    localparam logic signed [W-1:0] VPEAK   = 21'sd15360;  // spike threshold 30.0

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    // Clamp a wide signed value to the 21-bit range [-2^20, 2^20-1].
    function automatic logic signed [W-1:0] sat21(input logic signed [WI-1:0] x);
        logic signed [WI-1:0] hi;
        logic signed [WI-1:0] lo;
        hi = {{(WI-W+1){1'b0}}, {(W-1){1'b1}}};
        lo = {{(WI-W+1){1'b1}}, {(W-1){1'b0}}};
        if (x > hi) begin
            return hi[W-1:0];
        end else if (x < lo) begin
            return lo[W-1:0];
        end
        return x[W-1:0];
    endfunction

endpackage

// File: rtl/izh_neuron_fxmul.sv
// Signed fixed-point multiplier: full-precision product, floored by FRAC bits.
// The output keeps the full product width so callers decide where to truncate.
module izh_fxmul
    import izh_pkg::*;
#(
    parameter int WA = W,
    parameter int WB = W
) (
    input  logic signed [WA-1:0]    a_i,
    input  logic signed [WB-1:0]    b_i,
    output logic signed [WA+WB-1:0] p_o
);

    logic signed [WA+WB-1:0] prod;

    assign prod = (WA+WB)'(a_i) * (WA+WB)'(b_i);
    assign p_o  = prod >>> FRAC;

endmodule

// File: rtl/izh_neuron.sv
// Izhikevich neuron core: one forward-Euler step of (v, u) per clock in Q12.9,
// with spike detection and the (c, d) reset rule.
//
// state | meaning
// ------+-----------------------------------------------------------
// INIT  | first edge after reset: load v=c, u=b*c, final=c
// RUN   | Euler update every edge, spike reset when vn >= VPEAK
module izh_neuron
    import izh_pkg::*;
(
    input  logic                clk_i,
    input  logic                set_i,    // asynchronous, active low
    input  logic signed [W-1:0] i_i,
    input  logic signed [W-1:0] c_i,
    input  logic signed [W-1:0] d_i,
    output logic signed [W-1:0] v_o,
    output logic signed [W-1:0] final_o
);

    state_e              state_q, state_d;
    logic signed [W-1:0] v_q, v_d;
    logic signed [W-1:0] u_q, u_d;
    logic signed [W-1:0] final_q, final_d;

    logic signed [2*W-1:0]  vv;
    logic signed [3*W-1:0]  sq_p;
    logic signed [2*W-1:0]  lin;
    logic signed [2*W-1:0]  bv;
    logic signed [2*W-1:0]  bc;
    logic signed [WI-1:0]   diff;
    logic signed [WI+W-1:0] du_p;

    logic signed [WI-1:0] dv;
    logic signed [WI-1:0] vn_w;
    logic signed [WI-1:0] un_w;
    logic signed [WI-1:0] ud_w;
    logic signed [W-1:0]  vn;
    logic signed [W-1:0]  un;
    logic                 spike;

    izh_fxmul #(.WA(W), .WB(W)) u_mul_vv (
        .a_i (v_q),
        .b_i (v_q),
        .p_o (vv)
    );

    // The square term stays at full width; at |v| near 2^20 it exceeds 21 bits.
    izh_fxmul #(.WA(2*W), .WB(W)) u_mul_sq (
        .a_i (vv),
        .b_i (K_SQ),
        .p_o (sq_p)
    );

    izh_fxmul #(.WA(W), .WB(W)) u_mul_lin (
        .a_i (v_q),
        .b_i (K_LIN),
        .p_o (lin)
    );

    izh_fxmul #(.WA(W), .WB(W)) u_mul_bv (
        .a_i (v_q),
        .b_i (B_COEF),
        .p_o (bv)
    );

    izh_fxmul #(.WA(W), .WB(W)) u_mul_bc (
        .a_i (c_i),
        .b_i (B_COEF),
        .p_o (bc)
    );

    izh_fxmul #(.WA(WI), .WB(W)) u_mul_du (
        .a_i (diff),
        .b_i (A_COEF),
        .p_o (du_p)
    );

    // Euler datapath; all sums sign-extended to WI before combining.
    assign diff  = WI'(bv) - WI'(u_q);
    assign dv    = WI'(sq_p) + WI'(lin) + WI'(K_CONST) - WI'(u_q) + WI'(i_i);
    assign vn_w  = WI'(v_q) + (dv >>> DT_SHIFT);
    assign un_w  = WI'(u_q) + (WI'(du_p) >>> DT_SHIFT);
    assign vn    = sat21(vn_w);
    assign un    = sat21(un_w);
    assign ud_w  = WI'(un) + WI'(d_i);
    assign spike = (vn >= VPEAK);

    // Next-state and next-value selection.
    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        u_d     = u_q;
        final_d = final_q;
        case (state_q)
            INIT: begin
                v_d     = c_i;
                u_d     = sat21(WI'(bc));
                final_d = c_i;
                state_d = RUN;
            end
            RUN: begin
                if (spike) begin
                    v_d     = c_i;
                    u_d     = sat21(ud_w);
                    final_d = VPEAK;
                end else begin
                    v_d     = vn;
                    u_d     = un;
                    final_d = vn;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk_i or negedge set_i) begin
        if (!set_i) begin
            state_q <= INIT;
            v_q     <= '0;
            u_q     <= '0;
            final_q <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            u_q     <= u_d;
            final_q <= final_d;
        end
    end

    assign v_o     = v_q;
    assign final_o = final_q;

endmodule

// File: tb/tb_izh_neuron.sv
// Self-checking bench for izh_neuron: reset/init vector table, long resting,
// tonic and saturated runs, and randomized inputs, all against an integer model.
module tb_izh_neuron;

    localparam longint VP = 15360;

    logic                clk = 1'b0;
    logic                set_n;
    logic signed [20:0]  i_drv;
    logic signed [20:0]  c_drv;
    logic signed [20:0]  d_drv;
    logic signed [20:0]  v_o;
    logic signed [20:0]  final_o;

    int errors = 0;
    int checks = 0;

    // Reference state (u is internal to the DUT, kept here only in the model).
    longint mv, mu, mf;
    bit     m_init;

    izh_neuron dut (
        .clk_i   (clk),
        .set_i   (set_n),
        .i_i     (i_drv),
        .c_i     (c_drv),
        .d_i     (d_drv),
        .v_o     (v_o),
        .final_o (final_o)
    );

    always #5 clk = ~clk;

    function automatic longint sat(input longint x);
        if (x > 1048575)  return 1048575;
        if (x < -1048576) return -1048576;
        return x;
    endfunction

    // One neuron update using the current inputs, plain 64-bit arithmetic.
    task automatic model_edge();
        longint ii, ci, di, sq, dv, du, vn, un;
        ii = i_drv;
        ci = c_drv;
        di = d_drv;
        if (m_init) begin
            mv = ci;
            mu = (102 * ci) >>> 9;
            mf = ci;
            m_init = 1'b0;
        end else begin
            sq = (20 * ((mv * mv) >>> 9)) >>> 9;
            dv = sq + ((2560 * mv) >>> 9) + 71680 - mu + ii;
            du = (10 * (((102 * mv) >>> 9) - mu)) >>> 9;
            vn = sat(mv + (dv >>> 4));
            un = sat(mu + (du >>> 4));
            if (vn >= VP) begin
                mv = ci;
                mu = sat(un + di);
                mf = VP;
            end else begin
                mv = vn;
                mu = un;
                mf = vn;
            end
        end
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        chk({tag, " v"}, v_o, mv);
        chk({tag, " final"}, final_o, mf);
    endtask

    // Called 1 time unit after a rising edge: asserts set mid-cycle, checks the
    // outputs clear without an edge, holds across one edge, then releases.
    task automatic do_reset(input string tag);
        #2;
        set_n = 1'b0;
        #1;
        chk({tag, " async v"}, v_o, 0);
        chk({tag, " async final"}, final_o, 0);
        mv = 0; mu = 0; mf = 0; m_init = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, " held v"}, v_o, 0);
        set_n = 1'b1;
    endtask

    typedef struct {
        logic signed [20:0] c;
        logic signed [20:0] d;
        logic signed [20:0] i;
        logic signed [20:0] exp_v1;
        bit                 has_v2;
        logic signed [20:0] exp_v2;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int  dut_spk, mod_spk, rest_spk;
        real k, s, rest, vr;

        set_n = 1'b0;
        i_drv = '0;
        c_drv = '0;
        d_drv = '0;
        mv = 0; mu = 0; mf = 0; m_init = 1'b1;

        // Init loads: v = final = c after the first edge. For c = -56.0 the
        // second edge is worked by hand: dv = 62720 - 143360 + 71680 + 5712
        // = -3248, floor(-3248/16) = -203, v = -28875 = 0x1F8F35.
        tbl[0] = '{21'h1F9000, 21'h000980, 21'sd0,    21'h1F9000, 1'b1, 21'h1F8F35};
        tbl[1] = '{-21'sd33280, 21'sd4096, 21'sd5120, -21'sd33280, 1'b0, 21'sd0};
        tbl[2] = '{21'h100000, 21'sd0,     21'sd0,    21'h100000, 1'b0, 21'sd0};
        tbl[3] = '{21'h0FFFFF, 21'sd256,   21'sd0,    21'h0FFFFF, 1'b0, 21'sd0};
        tbl[4] = '{21'sd0,     21'sd0,     -21'sd512, 21'sd0,     1'b0, 21'sd0};

        #1;
        chk("power-on v", v_o, 0);
        chk("power-on final", final_o, 0);

        for (int n = 0; n < 5; n++) begin
            c_drv = tbl[n].c;
            d_drv = tbl[n].d;
            i_drv = tbl[n].i;
            do_reset("tbl rst");
            tick("tbl init");
            chk("tbl init v const", v_o, tbl[n].exp_v1);
            chk("tbl init final const", final_o, tbl[n].exp_v1);
            if (tbl[n].has_v2) begin
                tick("tbl step2");
                chk("tbl step2 v const", v_o, tbl[n].exp_v2);
            end
            for (int j = 0; j < 4; j++) tick("tbl run");
        end

        // Resting, I = 0. With K_SQ = 0.0390625 and b = 102/512 the stable
        // equilibrium of k*v^2 + (5-b)*v + 140 = 0 is near -75.3 rather than -70;
        // flooring in the u update can bias it by up to about 1.5.
        c_drv = 21'h1F9000;
        d_drv = 21'h000980;
        i_drv = '0;
        do_reset("rest rst");
        rest_spk = 0;
        for (int j = 0; j < 10000; j++) begin
            tick("rest");
            if (final_o == 21'sd15360) rest_spk++;
        end
        chk("rest spikes", rest_spk, 0);
        k    = 20.0 / 512.0;
        s    = 5.0 - 102.0 / 512.0;
        rest = (-s - $sqrt(s * s - 4.0 * k * 140.0)) / (2.0 * k) * 512.0;
        vr   = v_o;
        chk("rest settle within 2.0", ((vr - rest) <= 1024.0 && (rest - vr) <= 1024.0) ? 1 : 0, 1);

        // Tonic spiking, I = 30.0, continuing from rest.
        i_drv = 21'sd15360;
        dut_spk = 0;
        mod_spk = 0;
        for (int j = 0; j < 4000; j++) begin
            tick("tonic");
            if (mf == VP) mod_spk++;
            if (final_o == 21'sd15360) begin
                dut_spk++;
                chk("tonic v=c on spike", v_o, c_drv);
            end
        end
        chk("tonic spike count", dut_spk, mod_spk);
        chk("tonic at least 3 spikes", (dut_spk >= 3) ? 1 : 0, 1);

        // Saturated drive, I = max positive.
        i_drv = 21'h0FFFFF;
        dut_spk = 0;
        for (int j = 0; j < 2000; j++) begin
            tick("sat");
            if (final_o == 21'sd15360) begin
                dut_spk++;
                chk("sat v=c on spike", v_o, c_drv);
            end
        end
        chk("sat spiked", (dut_spk > 0) ? 1 : 0, 1);

        // Randomized inputs that may change on any cycle.
        for (int j = 0; j < 3000; j++) begin
            if ($urandom_range(0, 3) == 0) i_drv = 21'(int'($urandom_range(0, 40960)) - 10240);
            if ($urandom_range(0, 7) == 0) c_drv = 21'(int'($urandom_range(0, 20480)) - 40960);
            if ($urandom_range(0, 7) == 0) d_drv = 21'(int'($urandom_range(0, 5120)));
            if ($urandom_range(0, 49) == 0) i_drv = 21'($urandom);
            if ($urandom_range(0, 99) == 0) c_drv = 21'($urandom);
            tick("rand");
        end

        // Reset in the middle of a run, then a fresh init.
        do_reset("late rst");
        tick("late init");
        chk("late init v=c", v_o, c_drv);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
